atmos_light_estimate: RTL and testbench

- Sits directly downstream of the dark-channel stage in the dehaze pipeline.
- Consumes the dark-channel pixel stream together with its vsync/valid/clken qualifiers.
- Over each frame, finds the brightest dark-channel value (the atmospheric light estimate A) and its raster coordinates.
- At end of frame, publishes a clamped A for the transmission-estimation stage.

---
 rtl/atmos_light_estimate.sv | 115 +++++++++++
 tb/tb_atmos_light_estimate.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atmos_light_estimate.sv
// atmos_light_estimate: per-frame brightest dark-channel pixel (atmospheric light A) with position; optional temporal smoothing when ATMOS_IIR_EN is defined
module atmos_light_estimate #(
  parameter int         IMG_W_BITS = 11,
  parameter int         IMG_H_BITS = 11,
  parameter logic [7:0] A_MAX      = 8'd240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pre_dark_vsync,
  input  logic                  pre_dark_valid,
  input  logic                  pre_dark_clken,
  input  logic [7:0]            dark_value,
  output logic [7:0]            atmos_light,
  output logic [IMG_W_BITS-1:0] atmos_x,
  output logic [IMG_H_BITS-1:0] atmos_y,
  output logic                  atmos_valid,
  output logic                  frame_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  vsync_d1_q, vsync_d1_d, valid_d1_q, valid_d1_d, rise_q, rise_d;
  logic [7:0]            cur_max_q, cur_max_d;
  logic [IMG_W_BITS-1:0] col_q, col_d, max_x_q, max_x_d, x_q, x_d;
  logic [IMG_H_BITS-1:0] row_q, row_d, max_y_q, max_y_d, y_q, y_d;
  logic                  seen_q, seen_d;
  logic [7:0]            light_q, light_d;
  logic                  avalid_q, avalid_d, done_q, done_d;
  logic                  vs_rise, vs_fall, vl_fall, acc_en, pix_ok, upd, pub;
  logic [7:0]            a_clamp;

  assign vs_rise = pre_dark_vsync & ~vsync_d1_q;
  assign vs_fall = ~pre_dark_vsync & vsync_d1_q;
  assign vl_fall = ~pre_dark_valid & valid_d1_q;
  // A rise seen during LATCH is replayed from rise_q, so the IDLE cycle that follows already accumulates
  assign acc_en  = (state_q == ACCUM) || (state_q == IDLE && rise_q);
  assign pix_ok  = acc_en & pre_dark_valid & pre_dark_clken;
  assign upd     = pix_ok & (~seen_q | (dark_value > cur_max_q));
  assign pub     = (state_q == LATCH) & seen_q;
  assign a_clamp = (cur_max_q > A_MAX) ? A_MAX : cur_max_q;

`ifdef ATMOS_IIR_EN
  logic [9:0] iir_sum;
  assign iir_sum = {2'b00, light_q} + {1'b0, light_q, 1'b0} + {2'b00, a_clamp} + 10'd2;
`endif

  // Next-state: edge registers, FSM, frame accumulation (cleared whenever not accumulating) and published outputs
  always_comb begin
    vsync_d1_d = pre_dark_vsync;
    valid_d1_d = pre_dark_valid;
    rise_d     = vs_rise;
    state_d    = (state_q == IDLE)  ? ((vs_rise | rise_q) ? ACCUM : IDLE) :
                 (state_q == ACCUM) ? (vs_fall ? LATCH : ACCUM) : IDLE;
    cur_max_d  = !acc_en ? '0 : upd ? dark_value : cur_max_q;
    max_x_d    = !acc_en ? '0 : upd ? col_q : max_x_q;
    max_y_d    = !acc_en ? '0 : upd ? row_q : max_y_q;
    seen_d     = acc_en & (seen_q | pix_ok);
    col_d      = (!acc_en || vl_fall) ? '0 : (pix_ok && col_q != '1) ? col_q + 1'b1 : col_q;
    row_d      = !acc_en ? '0 : (vl_fall && row_q != '1) ? row_q + 1'b1 : row_q;
`ifdef ATMOS_IIR_EN
    light_d    = !pub ? light_q : avalid_q ? iir_sum[9:2] : a_clamp;
`else
    light_d    = pub ? a_clamp : light_q;
`endif
    x_d        = pub ? max_x_q : x_q;
    y_d        = pub ? max_y_q : y_q;
    avalid_d   = avalid_q | pub;
    done_d     = (state_q == LATCH);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vsync_d1_q <= 1'b0;
      valid_d1_q <= 1'b0;
      rise_q     <= 1'b0;
      cur_max_q  <= '0;
      max_x_q    <= '0;
      max_y_q    <= '0;
      seen_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      light_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      avalid_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_d1_q <= vsync_d1_d;
      valid_d1_q <= valid_d1_d;
      rise_q     <= rise_d;
      cur_max_q  <= cur_max_d;
      max_x_q    <= max_x_d;
      max_y_q    <= max_y_d;
      seen_q     <= seen_d;
      col_q      <= col_d;
      row_q      <= row_d;
      light_q    <= light_d;
      x_q        <= x_d;
      y_q        <= y_d;
      avalid_q   <= avalid_d;
      done_q     <= done_d;
    end
  end

  assign atmos_light = light_q;
  assign atmos_x     = x_q;
  assign atmos_y     = y_q;
  assign atmos_valid = avalid_q;
  assign frame_done  = done_q;
endmodule

// File: tb/tb_atmos_light_estimate.sv
// tb_atmos_light_estimate: directed frame scenarios for atmos_light_estimate
module tb_atmos_light_estimate;
  logic        clk = 1'b0;
  logic        rst, vs, vl, ck;
  logic [7:0]  dv;
  logic [7:0]  atmos_light;
  logic [10:0] atmos_x, atmos_y;
  logic        atmos_valid, frame_done;
  int          errs = 0, checks = 0;
  logic [7:0]  pix [0:7][0:7];
  logic [2:0]  fdp;
  logic [7:0]  m_a;
  logic [10:0] m_x, m_y;
  logic        m_v;

  atmos_light_estimate dut (
    .clk(clk), .rst(rst), .pre_dark_vsync(vs), .pre_dark_valid(vl), .pre_dark_clken(ck),
    .dark_value(dv), .atmos_light(atmos_light), .atmos_x(atmos_x), .atmos_y(atmos_y),
    .atmos_valid(atmos_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        pix[r][c] = v;
  endtask

  // fdp = frame_done sampled after the 1st, 2nd and 3rd edges following vsync low
  task automatic run_frame(input int w, input int h, input logic c, input bit b2b);
    if (!vs) begin
      vs = 1'b1;
      tick;
      tick;
    end
    for (int r = 0; r < h; r++) begin
      vl = 1'b1;
      ck = c;
      for (int x = 0; x < w; x++) begin
        dv = pix[r][x];
        tick;
      end
      vl = 1'b0;
      ck = 1'b0;
      dv = 8'd0;
      tick;
    end
    vs = 1'b0;
    tick;
    fdp[2] = frame_done;
    if (b2b) vs = 1'b1;
    tick;
    fdp[1] = frame_done;
    fdp[0] = 1'b0;
    if (!b2b) begin
      tick;
      fdp[0] = frame_done;
    end
  endtask

  function automatic logic [7:0] next_a(input logic [7:0] mx);
    logic [7:0] c;
    c = (mx > 8'd240) ? 8'd240 : mx;
`ifdef ATMOS_IIR_EN
    return m_v ? 8'((3 * int'(m_a) + int'(c) + 2) >> 2) : c;
`else
    return c;
`endif
  endfunction

  task automatic test_reset;
    rst = 1'b1; vs = 1'b0; vl = 1'b0; ck = 1'b0; dv = 8'd0;
    tick;
    tick;
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid, frame_done} !== 32'd0) begin
      errs++;
      $display("FAIL reset_outputs: got a=%0d x=%0d y=%0d v=%0b fd=%0b want all 0", atmos_light, atmos_x, atmos_y, atmos_valid, frame_done);
    end
    rst = 1'b0;
    tick;
    m_a = 8'd0; m_x = 11'd0; m_y = 11'd0; m_v = 1'b0;
  endtask

  task automatic test_single_max;
    fill(8'd50);
    pix[1][2] = 8'd200;
    run_frame(4, 3, 1'b1, 1'b0);
    m_a = next_a(8'd200); m_x = 11'd2; m_y = 11'd1; m_v = 1'b1;
    checks++;
    if (fdp !== 3'b010) begin
      errs++;
      $display("FAIL single_pulse: got %b want 010", fdp);
    end
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL single_out: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
  endtask

  task automatic test_tie_clamp;
    fill(8'd100);
    pix[0][0] = 8'd255;
    pix[2][3] = 8'd255;
    run_frame(4, 3, 1'b1, 1'b0);
    m_a = next_a(8'd255); m_x = 11'd0; m_y = 11'd0;
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL tie_clamp: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
  endtask

  task automatic test_empty;
    fill(8'd120);
    pix[0][1] = 8'd30;
    run_frame(4, 2, 1'b1, 1'b0);
    m_a = next_a(8'd120); m_x = 11'd0; m_y = 11'd0;
    run_frame(4, 0, 1'b1, 1'b0);
    checks++;
    if (fdp !== 3'b010) begin
      errs++;
      $display("FAIL empty_pulse: got %b want 010", fdp);
    end
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL empty_hold: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
    fill(8'd250);
    run_frame(4, 2, 1'b0, 1'b0);
    checks++;
    if (fdp !== 3'b010) begin
      errs++;
      $display("FAIL noclken_pulse: got %b want 010", fdp);
    end
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL noclken_hold: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
  endtask

  task automatic test_reset_mid;
    vs = 1'b1;
    tick;
    tick;
    vl = 1'b1; ck = 1'b1; dv = 8'd230;
    tick;
    dv = 8'd40;
    tick;
    rst = 1'b1; vs = 1'b0; vl = 1'b0; ck = 1'b0; dv = 8'd0;
    #1;
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid, frame_done} !== 32'd0) begin
      errs++;
      $display("FAIL midreset_outputs: got a=%0d x=%0d y=%0d v=%0b fd=%0b want all 0", atmos_light, atmos_x, atmos_y, atmos_valid, frame_done);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    m_a = 8'd0; m_x = 11'd0; m_y = 11'd0; m_v = 1'b0;
    fill(8'd20);
    pix[1][2] = 8'd90;
    run_frame(3, 2, 1'b1, 1'b0);
    m_a = next_a(8'd90); m_x = 11'd2; m_y = 11'd1; m_v = 1'b1;
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL midreset_frame: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
  endtask

  task automatic test_back_to_back;
    fill(8'd10);
    pix[1][1] = 8'd70;
    run_frame(4, 2, 1'b1, 1'b1);
    m_a = next_a(8'd70); m_x = 11'd1; m_y = 11'd1;
    checks++;
    if (fdp[2:1] !== 2'b01) begin
      errs++;
      $display("FAIL b2b_pulse1: got %b want 01", fdp[2:1]);
    end
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL b2b_frame1: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
    fill(8'd60);
    pix[0][0] = 8'd180;
    pix[1][3] = 8'd180;
    run_frame(4, 2, 1'b1, 1'b0);
    m_a = next_a(8'd180); m_x = 11'd0; m_y = 11'd0;
    checks++;
    if (fdp !== 3'b010) begin
      errs++;
      $display("FAIL b2b_pulse2: got %b want 010", fdp);
    end
    checks++;
    if ({atmos_light, atmos_x, atmos_y, atmos_valid} !== {m_a, m_x, m_y, m_v}) begin
      errs++;
      $display("FAIL b2b_frame2: got a=%0d x=%0d y=%0d v=%0b want a=%0d x=%0d y=%0d v=%0b", atmos_light, atmos_x, atmos_y, atmos_valid, m_a, m_x, m_y, m_v);
    end
  endtask

`ifdef ATMOS_IIR_EN
  task automatic test_iir;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    m_a = 8'd0; m_x = 11'd0; m_y = 11'd0; m_v = 1'b0;
    fill(8'd200);
    run_frame(2, 2, 1'b1, 1'b0);
    checks++;
    if (atmos_light !== 8'd200) begin
      errs++;
      $display("FAIL iir_first: got %0d want 200", atmos_light);
    end
    fill(8'd100);
    run_frame(2, 2, 1'b1, 1'b0);
    checks++;
    if (atmos_light !== 8'd175) begin
      errs++;
      $display("FAIL iir_second: got %0d want 175", atmos_light);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_max;
    test_tie_clamp;
    test_empty;
    test_reset_mid;
    test_back_to_back;
`ifdef ATMOS_IIR_EN
    test_iir;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
